// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;

   modport master (
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
      input  mem_ack_i, mem_rdata_i
   );

   modport slave (
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
      output mem_ack_i, mem_rdata_i
   );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: one load/store per req/ack bus transaction,
// with alignment checks, lane formatting and a bus timeout.
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        busy_o,
   load_store_unit_if.master mem
);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;

   logic        bad;
   logic [3:0]  be_fmt;
   logic [31:0] wd_fmt;
   logic [31:0] lane;
   logic [31:0] ld_fmt;

   always_comb begin
      bad    = 1'b0;
      be_fmt = 4'b1111;
      wd_fmt = req_wdata_i;
      unique case (req_size_i)
         2'b00: begin
            be_fmt = 4'b0001 << req_addr_i[1:0];
            wd_fmt = {4{req_wdata_i[7:0]}};
         end
         2'b01: begin
            bad    = req_addr_i[0];
            be_fmt = 4'b0011 << req_addr_i[1:0];
            wd_fmt = {2{req_wdata_i[15:0]}};
         end
         2'b10: bad = (req_addr_i[1:0] != 2'b00);
         default: bad = 1'b1;
      endcase
   end

   always_comb begin
      lane   = mem.mem_rdata_i >> {off_q, 3'b000};
      ld_fmt = lane;
      unique case (size_q)
         2'b00: ld_fmt = {{24{~uns_q & lane[7]}}, lane[7:0]};
         2'b01: ld_fmt = {{16{~uns_q & lane[15]}}, lane[15:0]};
         default: ld_fmt = lane;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      size_d  = size_q;
      uns_d   = uns_q;
      off_d   = off_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               we_d    = req_we_i;
               size_d  = req_size_i;
               uns_d   = req_unsigned_i;
               off_d   = req_addr_i[1:0];
               addr_d  = {req_addr_i[31:2], 2'b00};
               wdata_d = wd_fmt;
               be_d    = be_fmt;
               cnt_d   = 8'd0;
               err_d   = bad;
               if (bad) begin
                  rdata_d = 32'd0;
                  state_d = RESP;
               end else begin
                  state_d = BUS;
               end
            end
         end
         BUS: begin
            // ack takes priority over an expiring timeout
            if (mem.mem_ack_i) begin
               err_d   = 1'b0;
               rdata_d = we_q ? 32'd0 : ld_fmt;
               state_d = RESP;
            end else if (cnt_q == LAST) begin
               err_d   = 1'b1;
               rdata_d = 32'd0;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         off_q   <= 2'b00;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         be_q    <= 4'd0;
         err_q   <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         off_q   <= off_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   assign req_ready_o     = (state_q == IDLE);
   assign busy_o          = (state_q != IDLE);
   assign rsp_valid_o     = (state_q == RESP);
   assign rsp_err_o       = (state_q == RESP) & err_q;
   assign rsp_rdata_o     = rdata_q;
   assign mem.mem_req_o   = (state_q == BUS);
   assign mem.mem_we_o    = we_q;
   assign mem.mem_addr_o  = addr_q;
   assign mem.mem_wdata_o = wdata_q;
   assign mem.mem_be_o    = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a response scoreboard.
module tb_load_store_unit;

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_we_i = 1'b0;
   logic [1:0]  req_size_i = 2'b00;
   logic        req_unsigned_i = 1'b0;
   logic [31:0] req_addr_i = 32'd0;
   logic [31:0] req_wdata_i = 32'd0;
   logic        rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        busy_o;

   int tests = 0;
   int fails = 0;
   exp_t sb[$];

   load_store_unit_if bus();

   load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_we_i       (req_we_i),
      .req_size_i     (req_size_i),
      .req_unsigned_i (req_unsigned_i),
      .req_addr_i     (req_addr_i),
      .req_wdata_i    (req_wdata_i),
      .rsp_valid_o    (rsp_valid_o),
      .rsp_rdata_o    (rsp_rdata_o),
      .rsp_err_o      (rsp_err_o),
      .busy_o         (busy_o),
      .mem            (bus.master)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pop_cmp(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         chk({tag, "_err"}, {31'd0, rsp_err_o}, {31'd0, e.err});
         chk({tag, "_rdata"}, rsp_rdata_o, e.rdata);
      end
   endtask

   task automatic do_req(
      input string       tag,
      input bit          we,
      input logic [1:0]  sz,
      input bit          uns,
      input logic [31:0] addr,
      input logic [31:0] wd,
      input logic [31:0] rd,
      input int          wt,
      input bit          ack_en,
      input bit          exp_err,
      input logic [31:0] exp_rdata,
      input int          exp_req,
      input logic [31:0] exp_maddr,
      input logic [3:0]  exp_be,
      input logic [31:0] exp_wdata
   );
      int reqcyc;
      bit got;
      bit first;
      logic [31:0] s_addr, s_wdata;
      logic [3:0]  s_be;
      logic        s_we;
      exp_t e;
      reqcyc = 0;
      got = 1'b0;
      first = 1'b1;
      s_addr = '0; s_wdata = '0; s_be = '0; s_we = 1'b0;
      req_valid_i    = 1'b1;
      req_we_i       = we;
      req_size_i     = sz;
      req_unsigned_i = uns;
      req_addr_i     = addr;
      req_wdata_i    = wd;
      chk({tag, "_ready"}, {31'd0, req_ready_o}, 32'd1);
      e.err   = exp_err;
      e.rdata = exp_rdata;
      sb.push_back(e);
      step();
      req_valid_i = 1'b0;
      for (int k = 0; k < 40; k++) begin
         bus.mem_ack_i = 1'b0;
         if (rsp_valid_o) begin
            got = 1'b1;
            pop_cmp(tag);
            break;
         end
         if (bus.mem_req_o) begin
            if (first) begin
               s_addr  = bus.mem_addr_o;
               s_wdata = bus.mem_wdata_o;
               s_be    = bus.mem_be_o;
               s_we    = bus.mem_we_o;
               first   = 1'b0;
            end
            reqcyc++;
            if (ack_en && (reqcyc - 1 == wt)) begin
               bus.mem_ack_i   = 1'b1;
               bus.mem_rdata_i = rd;
            end
         end
         step();
      end
      bus.mem_ack_i = 1'b0;
      chk({tag, "_rsp_seen"}, {31'd0, got}, 32'd1);
      chk({tag, "_req_cycles"}, reqcyc, exp_req);
      if (exp_req != 0) begin
         chk({tag, "_maddr"}, s_addr, exp_maddr);
         chk({tag, "_be"}, {28'd0, s_be}, {28'd0, exp_be});
         chk({tag, "_we"}, {31'd0, s_we}, {31'd0, we});
         chk({tag, "_wdata"}, s_wdata, exp_wdata);
      end
      step();
      chk({tag, "_pulse"}, {31'd0, rsp_valid_o}, 32'd0);
      chk({tag, "_held"}, rsp_rdata_o, exp_rdata);
   endtask

   initial begin
      int accepts;
      int resps;
      bit seen;
      exp_t e;
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = 32'd0;

      rst = 1'b1;
      step();
      step();
      chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_memreq", {31'd0, bus.mem_req_o}, 32'd0);
      chk("rst_rspvalid", {31'd0, rsp_valid_o}, 32'd0);
      chk("rst_rdata", rsp_rdata_o, 32'd0);
      chk("rst_be", {28'd0, bus.mem_be_o}, 32'd0);
      rst = 1'b0;
      step();

      do_req("lw_wait2", 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 2, 1,
             0, 32'hDEADBEEF, 3, 32'h10, 4'b1111, 32'h0);
      do_req("lb_signed", 0, 2'b00, 0, 32'h13, 32'h0, 32'h80FF00FF, 0, 1,
             0, 32'hFFFFFF80, 1, 32'h10, 4'b1000, 32'h0);
      do_req("lbu", 0, 2'b00, 1, 32'h13, 32'h0, 32'h80FF00FF, 0, 1,
             0, 32'h00000080, 1, 32'h10, 4'b1000, 32'h0);
      do_req("lhu", 0, 2'b01, 1, 32'h12, 32'h0, 32'h80FF00FF, 0, 1,
             0, 32'h000080FF, 1, 32'h10, 4'b1100, 32'h0);
      do_req("lh_signed", 0, 2'b01, 0, 32'h12, 32'h0, 32'h80FF00FF, 1, 1,
             0, 32'hFFFF80FF, 2, 32'h10, 4'b1100, 32'h0);
      do_req("sh", 1, 2'b01, 0, 32'h22, 32'h11FF11FF, 32'hCAFEF00D, 0, 1,
             0, 32'h0, 1, 32'h20, 4'b1100, 32'h11FF11FF);
      do_req("sb", 1, 2'b00, 0, 32'h21, 32'h000000AB, 32'hCAFEF00D, 1, 1,
             0, 32'h0, 2, 32'h20, 4'b0010, 32'hABABABAB);
      do_req("sw", 1, 2'b10, 0, 32'h104, 32'h12345678, 32'h0, 0, 1,
             0, 32'h0, 1, 32'h104, 4'b1111, 32'h12345678);
      do_req("lw_misalign", 0, 2'b10, 0, 32'h102, 32'h0, 32'h0, 0, 1,
             1, 32'h0, 0, 32'h0, 4'b0000, 32'h0);
      do_req("lh_misalign", 0, 2'b01, 0, 32'h101, 32'h0, 32'h0, 0, 1,
             1, 32'h0, 0, 32'h0, 4'b0000, 32'h0);
      do_req("size11", 0, 2'b11, 0, 32'h100, 32'h0, 32'h0, 0, 1,
             1, 32'h0, 0, 32'h0, 4'b0000, 32'h0);
      do_req("lw_ok2", 0, 2'b10, 0, 32'h8, 32'h0, 32'h0BADF00D, 0, 1,
             0, 32'h0BADF00D, 1, 32'h8, 4'b1111, 32'h0);
      do_req("timeout", 0, 2'b10, 0, 32'h30, 32'h0, 32'h0, 0, 0,
             1, 32'h0, 16, 32'h30, 4'b1111, 32'h0);
      do_req("ack_last", 0, 2'b10, 0, 32'h34, 32'h0, 32'h5A5AA5A5, 15, 1,
             0, 32'h5A5AA5A5, 16, 32'h34, 4'b1111, 32'h0);

      // reset in the middle of a bus transaction
      req_valid_i = 1'b1;
      req_we_i    = 1'b0;
      req_size_i  = 2'b10;
      req_addr_i  = 32'h50;
      step();
      req_valid_i = 1'b0;
      step();
      step();
      chk("rstbus_req_before", {31'd0, bus.mem_req_o}, 32'd1);
      rst = 1'b1;
      step();
      chk("rstbus_memreq", {31'd0, bus.mem_req_o}, 32'd0);
      chk("rstbus_ready", {31'd0, req_ready_o}, 32'd1);
      rst = 1'b0;
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = 32'hFFFFFFFF;
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         if (rsp_valid_o) seen = 1'b1;
      end
      bus.mem_ack_i = 1'b0;
      chk("late_ack_ignored", {31'd0, seen}, 32'd0);
      chk("late_ack_busy", {31'd0, busy_o}, 32'd0);

      // back-to-back loads with req_valid_i held and a zero-wait bus
      accepts = 0;
      resps = 0;
      req_valid_i     = 1'b1;
      req_we_i        = 1'b0;
      req_size_i      = 2'b10;
      req_unsigned_i  = 1'b0;
      req_addr_i      = 32'h40;
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = 32'h13572468;
      for (int i = 0; i < 9; i++) begin
         chk("b2b_ready", {31'd0, req_ready_o}, {31'd0, (i % 3) == 0});
         chk("b2b_busy", {31'd0, busy_o}, {31'd0, (i % 3) != 0});
         if (req_ready_o) begin
            accepts++;
            e.err = 1'b0;
            e.rdata = 32'h13572468;
            sb.push_back(e);
         end
         if (rsp_valid_o) begin
            resps++;
            pop_cmp("b2b");
         end
         if (i == 8) req_valid_i = 1'b0;
         step();
      end
      bus.mem_ack_i = 1'b0;
      chk("b2b_accepts", accepts, 32'd3);
      chk("b2b_resps", resps, 32'd3);
      chk("sb_drained", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage between the execute datapath and the data-memory bus.
- Accepts one load or store request per transaction:
  - address from the ALU result;
  - store data from the rs2 register-file read port.
- Runs a req/ack transaction on the data bus.
- Returns aligned, sign- or zero-extended load data that drives the core's mem_rdata_i input. Asserts busy_o so the core stalls while the transaction is in flight.

Parameters:
TIMEOUT_CYCLES, 16, bus cycles without mem_ack_i before the transaction is aborted with an error (legal range 2..255)

Ports:
clk  input  1  core clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
req_valid_i  input  1  execute stage presents a memory operation
req_ready_o  output  1  unit idle and able to accept a request
req_we_i  input  1  1 = store, 0 = load
req_size_i  input  2  00 byte, 01 halfword, 10 word, 11 illegal
req_unsigned_i  input  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr_i  input  32  byte address (ALU result)
req_wdata_i  input  32  store data (rs2 value)
rsp_valid_o  output  1  one-cycle pulse: transaction complete
rsp_rdata_o  output  32  extended load data (0 for stores and errors)
rsp_err_o  output  1  valid with rsp_valid_o: misaligned, illegal size or timeout
busy_o  output  1  high from accept until the rsp_valid_o cycle inclusive
mem_req_o  output  1  bus request
mem_we_o  output  1  bus write enable
mem_addr_o  output  32  word-aligned address, bits [1:0] = 0
mem_wdata_o  output  32  lane-replicated store data
mem_be_o  output  4  byte enables, bit n = byte lane n
mem_ack_i  input  1  bus completes the request this cycle
mem_rdata_i  input  32  raw bus read word, valid when mem_ack_i = 1

Behaviour:
- FSM states: IDLE, BUS, RESP.
  - req_ready_o = (state == IDLE).
  - Handshake fires on req_valid_i & req_ready_o.
- Accept cycle:
  - Register we, size, unsigned flag, addr[1:0] and the formatted bus fields.
  - Check alignment:
    - halfword with addr[0] = 1 → misaligned;
    - word with addr[1:0] != 0 → misaligned;
    - size 11 → illegal.
  - Error case: next state RESP with err = 1; mem_req_o is never raised.
  - Otherwise: next state BUS.
- BUS state:
  - mem_req_o = 1. mem_we_o, mem_addr_o, mem_wdata_o and mem_be_o are held stable until ack.
  - A timeout counter starts at 0 on entry and increments each BUS cycle without ack.
  - mem_ack_i = 1 → capture the formatted load data, go to RESP with err = 0.
  - Counter reaches TIMEOUT_CYCLES-1 without ack → go to RESP with err = 1. An ack in that same cycle wins over the timeout.
- RESP state (exactly one cycle):
  - rsp_valid_o = 1; rsp_err_o valid.
  - Then go to IDLE. A new request can be accepted the following cycle.
- Latency:
  - Accept at cycle N → mem_req_o high from N+1.
  - Ack at cycle M → rsp_valid_o at M+1.
  - Zero-wait bus (ack at N+1) → response at N+2.
  - Error before any bus access → response at N+1.
- Store formatting:
  - byte: wdata = {4{d[7:0]}}, be = 0001 << addr[1:0];
  - halfword: wdata = {2{d[15:0]}}, be = 0011 << addr[1:0];
  - word: wdata = d, be = 1111.
- Load formatting:
  - Select the lane as rdata >> (8*addr[1:0]).
  - Byte/halfword are sign- or zero-extended per req_unsigned_i; word is passed unchanged.
  - mem_we_o = 0. mem_be_o uses the same pattern as stores (informational).
- rsp_rdata_o:
  - Updated only in the RESP cycle, then held until the next response.
  - Store or error responses set it to 0.
- Ignored inputs:
  - mem_ack_i is ignored outside BUS.
  - req_valid_i is ignored outside IDLE; the requester must hold it until accepted.
- Reset:
  - State IDLE; all outputs 0, except req_ready_o = 1 in the first cycle after reset.
  - Counter cleared.
  - Reset during BUS drops mem_req_o at the same edge; a late ack after reset is ignored.

Test Plan:
- Word load addr 0x0000_0010, mem returns 0xDEADBEEF after 2 wait cycles → mem_addr_o = 0x10, be = 1111, rsp_rdata_o = 0xDEADBEEF, err = 0, rsp_valid_o exactly 3 cycles after mem_req_o rises.
- Signed byte load addr 0x13, mem_rdata_i = 0x80FF00FF, zero-wait → rsp_rdata_o = 0xFFFFFF80. Same with req_unsigned_i = 1 → 0x00000080. Halfword unsigned at 0x12 → 0x000080FF.
- Halfword store addr 0x22, data 0x11FF11FF → mem_we_o = 1, mem_addr_o = 0x20, mem_be_o = 1100, mem_wdata_o = 0x11FF11FF, rsp_rdata_o = 0. Byte store addr 0x21, data 0x000000AB → be = 0010, wdata = 0xABABABAB.
- Word load addr 0x0000_0102 → rsp_valid_o with err = 1 one cycle after accept, mem_req_o never asserted. Size 11 → same result.
- No ack, TIMEOUT_CYCLES = 16 → mem_req_o high exactly 16 cycles, then rsp_err_o = 1. Ack on the 16th cycle → err = 0, data returned.
- rst pulsed high during BUS → mem_req_o = 0 and req_ready_o = 1 after the edge. Ack arriving afterward produces no rsp_valid_o. Back-to-back requests with req_valid_i held high → one accept per transaction, busy_o low only in idle cycles.
